// File: rtl/fpmul_host_if.sv
// Host-side driver for the FP multiplier Start/Done handshake: operand FIFO,
// single-outstanding issue FSM with watchdog, and an in-order result register.
module fpmul_host_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic [6:0]  out_flags,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [31:0] mul_p,
    input  logic        mul_of,
    input  logic        mul_uf,
    input  logic        mul_nan,
    input  logic        mul_inf,
    input  logic        mul_dnf,
    input  logic        mul_zf,
    output logic        busy,
    output logic [15:0] ops_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [31:0] fifo_a_q [DEPTH];
    logic [31:0] fifo_b_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic [31:0] mul_a_q, mul_b_q;
    logic        out_valid_q;
    logic [31:0] out_p_q;
    logic [6:0]  out_flags_q;
    logic [15:0] ops_cnt_q;

    logic        push, pop, load_op;
    logic        res_load;
    logic [31:0] res_p;
    logic [6:0]  res_flags;

    assign in_ready  = (count_q < FULL_CNT);
    assign push      = in_valid & in_ready;
    assign pop       = (state_q == S_ISSUE);
    assign mul_start = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_flags = out_flags_q;
    assign ops_cnt   = ops_cnt_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        load_op   = 1'b0;
        res_load  = 1'b0;
        res_p     = '0;
        res_flags = '0;
        case (state_q)
            S_IDLE: begin
                // Only issue when the result slot is free or being drained this cycle.
                if ((count_q != '0) && (!out_valid_q || out_ready)) begin
                    load_op = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (mul_done) begin
                    res_load  = 1'b1;
                    res_p     = mul_p;
                    res_flags = {1'b0, mul_of, mul_uf, mul_nan, mul_inf, mul_dnf, mul_zf};
                    state_d   = S_IDLE;
                end else if (timer_q == TIMER_END) begin
                    res_load  = 1'b1;
                    res_p     = '0;
                    res_flags = 7'b1000000;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_flags_q <= '0;
            ops_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (load_op) begin
                mul_a_q <= fifo_a_q[rd_ptr_q];
                mul_b_q <= fifo_b_q[rd_ptr_q];
            end
            // A fresh result takes precedence over the consume-side clear.
            if (res_load) begin
                out_valid_q <= 1'b1;
                out_p_q     <= res_p;
                out_flags_q <= res_flags;
                ops_cnt_q   <= ops_cnt_q + 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= in_a;
            fifo_b_q[wr_ptr_q] <= in_b;
        end
    end

endmodule

// File: tb/tb_fpmul_host_if.sv
// Bench for fpmul_host_if: directed + randomized ops against a reactive
// multiplier model and an in-order expected-result queue.
module tb_fpmul_host_if;

    localparam int unsigned DEPTH_T = 4;
    localparam int unsigned TO_T    = 15;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [5:0]  f;
        int unsigned dly;   // cycles from start to done; 0 = never answers
    } op_t;

    typedef struct {
        logic [31:0] p;
        logic [6:0]  f;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_p;
    logic [6:0]  out_flags;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic        mul_done = 1'b0;
    logic [31:0] mul_p = '0;
    logic        mul_of = 1'b0, mul_uf = 1'b0, mul_nan = 1'b0;
    logic        mul_inf = 1'b0, mul_dnf = 1'b0, mul_zf = 1'b0;
    logic        busy;
    logic [15:0] ops_cnt;

    fpmul_host_if #(.DEPTH(DEPTH_T), .TIMEOUT(TO_T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .mul_of(mul_of), .mul_uf(mul_uf), .mul_nan(mul_nan),
        .mul_inf(mul_inf), .mul_dnf(mul_dnf), .mul_zf(mul_zf),
        .busy(busy), .ops_cnt(ops_cnt)
    );

    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    op_t  iss_q[$];
    res_t exp_q[$];
    op_t  cur_push;
    op_t  cur;
    bit   pend = 0;
    int unsigned pend_cnt = 0;
    bit   stray_req = 0;
    bit   rand_ready = 0;

    int unsigned cyc = 0, n_push = 0, n_start = 0, produced = 0;
    int unsigned last_push_cyc = 0, last_start_cyc = 0, last_res_cyc = 0;
    logic [31:0] last_res_p = '0;
    logic [6:0]  last_res_f = '0;
    bit          in_flight = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_start = 1'b0;
    logic [31:0] prev_p = '0;
    logic [6:0]  prev_f = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A multiply only yields its product if done lands within the watchdog window.
    function automatic res_t expect_of(input op_t o);
        res_t r;
        if (o.dly == 0 || o.dly > TO_T) begin
            r.p = 32'h0;
            r.f = 7'b1000000;
        end else begin
            r.p = o.p;
            r.f = {1'b0, o.f};
        end
        return r;
    endfunction

    always @(negedge clk) begin : model_and_monitor
        bit   new_res;
        int   occ;
        res_t e;
        op_t  o;
        if (!rst) begin
            iss_q.delete();
            exp_q.delete();
            pend = 0; stray_req = 0; in_flight = 0;
            n_push = 0; n_start = 0; produced = 0;
            prev_valid = 1'b0; prev_ready = 1'b0; prev_start = 1'b0;
            mul_done = 1'b0;
        end else begin
            cyc++;
            mul_done = 1'b0;
            mul_p = $urandom;
            {mul_of, mul_uf, mul_nan, mul_inf, mul_dnf, mul_zf} = 6'($urandom);
            if (pend) begin
                chk("mul_a_hold", mul_a, cur.a);
                chk("mul_b_hold", mul_b, cur.b);
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend = 0;
                    mul_done = 1'b1;
                    mul_p = cur.p;
                    {mul_of, mul_uf, mul_nan, mul_inf, mul_dnf, mul_zf} = cur.f;
                end
            end
            if (stray_req) begin
                stray_req = 0;
                mul_done = 1'b1;
                mul_p = 32'hDEADBEEF;
                {mul_of, mul_uf, mul_nan, mul_inf, mul_dnf, mul_zf} = 6'b111111;
            end

            if (prev_valid && !prev_ready) begin
                chk("out_hold_valid", 32'(out_valid), 32'd1);
                chk("out_hold_p", out_p, prev_p);
                chk("out_hold_flags", 32'(out_flags), 32'(prev_f));
            end
            new_res = out_valid && !(prev_valid && !prev_ready);
            if (new_res) begin
                produced++;
                in_flight = 0;
                last_res_cyc = cyc;
                last_res_p = out_p;
                last_res_f = out_flags;
                chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_p", out_p, e.p);
                    chk("out_flags", 32'(out_flags), 32'(e.f));
                end
                chk("ops_cnt", 32'(ops_cnt), produced & 32'hFFFF);
            end

            occ = int'(n_push) - int'(n_start);
            chk("in_ready", 32'(in_ready), 32'(occ < int'(DEPTH_T)));
            chk("busy", 32'(busy), 32'(occ > 0 || mul_start || in_flight));

            if (mul_start) begin
                chk("start_pulse", 32'(prev_start), 32'd0);
                chk("start_gated", 32'(out_valid), 32'd0);
                n_start++;
                last_start_cyc = cyc;
                in_flight = 1;
                chk("issue_expected", 32'(iss_q.size() != 0), 32'd1);
                if (iss_q.size() != 0) begin
                    cur = iss_q.pop_front();
                    chk("mul_a", mul_a, cur.a);
                    chk("mul_b", mul_b, cur.b);
                    pend = (cur.dly != 0);
                    pend_cnt = cur.dly;
                end
            end

            if (in_valid && in_ready) begin
                o = cur_push;
                o.a = in_a;
                o.b = in_b;
                iss_q.push_back(o);
                exp_q.push_back(expect_of(o));
                n_push++;
                last_push_cyc = cyc;
            end

            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_start = mul_start;
            prev_p = out_p;
            prev_f = out_flags;
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = 1'($urandom);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                        input logic [5:0] f, input int unsigned dly);
        bit acc;
        int unsigned n;
        in_a = a;
        in_b = b;
        cur_push.a = a; cur_push.b = b; cur_push.p = p; cur_push.f = f; cur_push.dly = dly;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            step(1);
            n++;
        end while (!acc && n < 300);
        in_valid = 1'b0;
        chk("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 3000) begin
            step(1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin : stimulus
        int unsigned s0, sel, dly, n;
        step(2);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ops_cnt", 32'(ops_cnt), 32'd0);
        chk("rst_out_p", out_p, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        step(1);
        rst = 1'b1;

        // 1.5 * 2.0 on the normal path
        out_ready = 1'b1;
        push(32'h3FC00000, 32'h40000000, 32'h40400000, 6'b0, 8);
        drain();
        chk("t1_issue_lat", last_start_cyc - last_push_cyc, 32'd2);
        chk("t1_result_lat", last_res_cyc - last_start_cyc, 32'd9);
        chk("t1_p", last_res_p, 32'h40400000);
        chk("t1_ops_cnt", 32'(ops_cnt), 32'd1);

        // backpressure: fill the FIFO behind an unconsumed result
        out_ready = 1'b0;
        s0 = n_start;
        for (int i = 0; i < 5; i++) push($urandom, $urandom, $urandom, 6'($urandom), 8);
        step(20);
        chk("t2_full", 32'(in_ready), 32'd0);
        chk("t2_one_issue", n_start - s0, 32'd1);
        chk("t2_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        push($urandom, $urandom, $urandom, 6'($urandom), 8);
        drain();
        chk("t2_ops_cnt", 32'(ops_cnt), 32'd7);

        // abnormal fast path with NaN
        push($urandom, $urandom, 32'h7FFFFFFF, 6'b001000, 5);
        drain();
        chk("t3_result_lat", last_res_cyc - last_start_cyc, 32'd6);
        chk("t3_flags", 32'(last_res_f), 32'h08);
        chk("t3_p", last_res_p, 32'h7FFFFFFF);

        // watchdog, then a stray done while idle must be ignored
        out_ready = 1'b0;
        push($urandom, $urandom, $urandom, 6'($urandom), 0);
        push($urandom, $urandom, 32'h12345678, 6'b000010, 8);
        n = 0;
        while (!out_valid && n < 100) begin step(1); n++; end
        chk("t4_timeout_seen", 32'(out_valid), 32'd1);
        step(1);
        chk("t4_timeout_lat", last_res_cyc - last_start_cyc, 32'd16);
        chk("t4_flags", 32'(last_res_f), 32'h40);
        chk("t4_p", last_res_p, 32'h0);
        s0 = n_start;
        step(2);
        stray_req = 1;
        step(4);
        chk("t4_stray_p", out_p, 32'h0);
        chk("t4_no_issue", n_start - s0, 32'd0);
        out_ready = 1'b1;
        drain();
        chk("t4_next_p", last_res_p, 32'h12345678);
        chk("t4_ops_cnt", 32'(ops_cnt), 32'd10);

        // asynchronous reset in the middle of a wait
        push($urandom, $urandom, $urandom, 6'($urandom), 12);
        n = 0;
        while (!in_flight && n < 50) begin step(1); n++; end
        step(4);
        rst = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_mul_start", 32'(mul_start), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ops_cnt", 32'(ops_cnt), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        step(2);
        rst = 1'b1;
        push(32'h40400000, 32'h40000000, 32'h40C00000, 6'b0, 8);
        drain();
        chk("t5_p", last_res_p, 32'h40C00000);
        chk("t5_ops_cnt_after", 32'(ops_cnt), 32'd1);

        // random stream with random consumer backpressure and boundary delays
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: dly = 0;
                1: dly = 5;
                2: dly = TO_T;
                3: dly = TO_T + 1;
                4: dly = 1;
                default: dly = $urandom_range(2, 14);
            endcase
            push($urandom, $urandom, $urandom, 6'($urandom), dly);
            step($urandom_range(0, 2));
        end
        drain();
        rand_ready = 0;
        out_ready = 1'b1;
        step(2);
        chk("t6_ops_cnt", 32'(ops_cnt), produced & 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
